dual_data_responder: RTL



---
 rtl/dual_data_responder.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/dual_data_responder.sv
// dual_data_responder: serialises a pair of load/store requests from the
// dual-issue pipeline onto one sram-like data bus. Slot 01 is always issued
// before slot 02, and responses are handed back to the slots in that same order.
module dual_data_responder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,

    // Paired requests from the pre-memory stage
    input  logic                  req_01,
    input  logic                  wr_01,
    input  logic [1:0]            size_01,
    input  logic [ADDR_WIDTH-1:0] addr_01,
    input  logic [3:0]            wstrb_01,
    input  logic [DATA_WIDTH-1:0] wdata_01,
    input  logic                  req_02,
    input  logic                  wr_02,
    input  logic [1:0]            size_02,
    input  logic [ADDR_WIDTH-1:0] addr_02,
    input  logic [3:0]            wstrb_02,
    input  logic [DATA_WIDTH-1:0] wdata_02,
    output logic                  up_addr_ok,

    // Single downstream data bus
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic [3:0]            data_wstrb,
    output logic [DATA_WIDTH-1:0] data_wdata,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [DATA_WIDTH-1:0] data_rdata,

    // Per-slot responses to the memory stage
    output logic                  data_cache_data_ok_01,
    output logic [DATA_WIDTH-1:0] data_cache_rdata_01,
    output logic                  data_cache_data_ok_02,
    output logic [DATA_WIDTH-1:0] data_cache_rdata_02
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue1,
        StIssue2,
        StWait
    } state_e;

    typedef struct packed {
        logic                  valid;
        logic                  wr;
        logic [1:0]            size;
        logic [ADDR_WIDTH-1:0] addr;
        logic [3:0]            wstrb;
        logic [DATA_WIDTH-1:0] wdata;
    } slot_t;

    state_e      state_q, state_d;
    slot_t       slot1_q, slot1_d;
    slot_t       slot2_q, slot2_d;
    logic        done1_q, done1_d;
    logic        done2_q, done2_d;
    logic [1:0]  outstanding_q, outstanding_d;
    // 0 = next response belongs to slot 01, 1 = slot 02
    logic        resp_slot_q, resp_slot_d;

    logic        fire;
    logic        resp_live;
    logic        ok1;
    logic        ok2;
    logic        all_done;

    // Response qualification: a data_ok with nothing outstanding is a stray and is dropped.
    always_comb begin
        fire      = data_req & data_addr_ok;
        resp_live = data_data_ok & (outstanding_q != 2'd0);
        ok1       = resp_live & ~resp_slot_q;
        ok2       = resp_live & resp_slot_q;
        // Counts a response arriving this cycle, so completion can be taken on this edge.
        all_done  = (~slot1_q.valid | done1_q | ok1) & (~slot2_q.valid | done2_q | ok2);
    end

    // Downstream request mux and upstream handshake, driven from the current state.
    always_comb begin
        up_addr_ok = 1'b0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'd0;
        data_addr  = '0;
        data_wstrb = 4'd0;
        data_wdata = '0;
        unique case (state_q)
            StIdle: begin
                up_addr_ok = 1'b1;
            end
            StIssue1: begin
                data_req   = 1'b1;
                data_wr    = slot1_q.wr;
                data_size  = slot1_q.size;
                data_addr  = slot1_q.addr;
                data_wstrb = slot1_q.wstrb;
                data_wdata = slot1_q.wdata;
            end
            StIssue2: begin
                data_req   = 1'b1;
                data_wr    = slot2_q.wr;
                data_size  = slot2_q.size;
                data_addr  = slot2_q.addr;
                data_wstrb = slot2_q.wstrb;
                data_wdata = slot2_q.wdata;
            end
            StWait: begin
                up_addr_ok = 1'b0;
            end
        endcase
    end

    // Response routing: pass-through, no added latency.
    always_comb begin
        data_cache_data_ok_01 = ok1;
        data_cache_data_ok_02 = ok2;
        data_cache_rdata_01   = data_rdata;
        data_cache_rdata_02   = data_rdata;
    end

    // Next-state logic: FSM, slot latches, completion flags and response pointer.
    always_comb begin
        state_d     = state_q;
        slot1_d     = slot1_q;
        slot2_d     = slot2_q;
        done1_d     = done1_q | ok1;
        done2_d     = done2_q | ok2;
        resp_slot_d = resp_slot_q | ok1;

        unique case (state_q)
            StIdle: begin
                if (req_01 | req_02) begin
                    slot1_d.valid = req_01;
                    slot1_d.wr    = wr_01;
                    slot1_d.size  = size_01;
                    slot1_d.addr  = addr_01;
                    slot1_d.wstrb = wstrb_01;
                    slot1_d.wdata = wdata_01;
                    slot2_d.valid = req_02;
                    slot2_d.wr    = wr_02;
                    slot2_d.size  = size_02;
                    slot2_d.addr  = addr_02;
                    slot2_d.wstrb = wstrb_02;
                    slot2_d.wdata = wdata_02;
                    done1_d       = 1'b0;
                    done2_d       = 1'b0;
                    resp_slot_d   = ~req_01;
                    state_d       = req_01 ? StIssue1 : StIssue2;
                end
            end
            StIssue1: begin
                if (data_addr_ok) begin
                    state_d = slot2_q.valid ? StIssue2 : StWait;
                end
            end
            StIssue2: begin
                if (data_addr_ok) begin
                    state_d = all_done ? StIdle : StWait;
                end
            end
            StWait: begin
                if (all_done) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // Outstanding counter: accept and response in one cycle cancel out.
    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({fire, resp_live})
            2'b10:   outstanding_d = outstanding_q + 2'd1;
            2'b01:   outstanding_d = outstanding_q - 2'd1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // State registers; reset drops any latched pair and all outstanding tracking.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StIdle;
            slot1_q       <= '0;
            slot2_q       <= '0;
            done1_q       <= 1'b0;
            done2_q       <= 1'b0;
            outstanding_q <= 2'd0;
            resp_slot_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot1_q       <= slot1_d;
            slot2_q       <= slot2_d;
            done1_q       <= done1_d;
            done2_q       <= done2_d;
            outstanding_q <= outstanding_d;
            resp_slot_q   <= resp_slot_d;
        end
    end

endmodule
